uart_tx_serializer: RTL and testbench
=====================================

# uart_tx_serializer

Serializes one parallel byte per transaction onto the UART TX line with configurable data width, parity and stop bits. Sits directly downstream of the baud divider stage and consumes its output as a one-cycle `baud_tick` enable; the divided signal is never used as a clock. Upstream logic hands over bytes via a valid/ready handshake.

## Interface
- `DATA_BITS`, 8: payload bits per frame, legal range 5–9.
- `PARITY`, 0: parity mode; 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.
- `clock`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `baud_tick`  in  1  one-`clock`-wide pulse per bit period, from the divider stage.
- `tx_data`  in  DATA_BITS  byte to send; sampled only on handshake.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  block can accept a byte; high exactly in IDLE.
- `tx`  out  1  serial line, registered; idle level 1.
- `tx_busy`  out  1  high in any state except IDLE.
- `tx_done`  out  1  one-cycle pulse when the last stop bit completes.

## Operation
- Handshake: a transfer occurs on a `clock` edge where `tx_valid && tx_ready`.
  - On transfer, `tx_data` is latched into a shift register and the parity bit is computed from the latched value.
  - State moves IDLE→SYNC.
- SYNC: hold `tx`=1. On the next `baud_tick`, drive `tx`=0 (start bit) and move to START.
- START: on `baud_tick`, drive `tx` = shreg[0] (LSB first), shift right, clear bit_cnt, move to DATA.
- DATA: on `baud_tick`:
  - If bit_cnt == DATA_BITS-1: go to PARITY with `tx`=parity bit when PARITY≠0; otherwise go to STOP with `tx`=1.
  - Else: `tx` = next bit, bit_cnt+1.
- PARITY: on `baud_tick`, drive `tx`=1, clear stop_cnt, move to STOP.
- STOP: on `baud_tick`:
  - If stop_cnt == STOP_BITS-1: go to IDLE and pulse `tx_done`.
  - Else: stop_cnt+1.
- Parity values:
  - Even: XOR-reduction of the data bits.
  - Odd: inverted XOR-reduction.
- `baud_tick` is ignored in IDLE.
- A `baud_tick` in the same cycle as the handshake is not counted; SYNC waits for the following tick.
- `tx_data` changes while busy have no effect.
- bit_cnt is sized $clog2(DATA_BITS); stop_cnt is 1 bit.

## Timing
- Reset values: `tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0; state IDLE; counters 0.
- Reset asserted mid-frame: on the next edge, `tx` returns to 1, state returns to IDLE, no `tx_done` pulse. The partial frame is abandoned.
- Start-bit latency: the start bit begins on the first `baud_tick` after the handshake edge (1 cycle + ≤1 tick period).
- Every bit, including start, parity and stop, lasts exactly one tick period. `tx` changes only on `baud_tick` edges, except when reset forces it to 1.
- Frame length is 1 + DATA_BITS + (PARITY≠0) + STOP_BITS tick periods.
- `tx_done` and `tx_ready` rise on the same edge. A new handshake is possible on that edge's following cycle, giving back-to-back frames with zero idle bit time beyond the SYNC wait.
- `tx_busy` = !`tx_ready` at all times.

## Structure
- Shared package `uart_pkg`:
  - State enum: IDLE, SYNC, START, DATA, PARITY, STOP.
  - Parity mode constants: PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2.
  - Reused later by the RX block.
- Single module, no sub-module. Parity is an inline reduction XOR.
- Tick generation stays in the divider stage. The bench drives `baud_tick` directly.

## Test plan
- Reset then idle: hold `rst_n`=0 for 3 cycles, release, tick every 4 clocks, `tx_valid`=0 → `tx` stays 1 and `tx_ready` stays 1 for 100 cycles.
- 8N1, send 0xA5, tick every 4 clocks → `tx` sequence per tick is 0,1,0,1,0,0,1,0,1,1. Then one `tx_done` pulse, `tx_ready` back to 1, total 10 tick periods.
- PARITY=1 send 0x07, then PARITY=2 send 0x07 → parity bit is 1 (even), then 0 (odd). Frame is 11 bits.
- STOP_BITS=2, back-to-back 0x00 then 0xFF with `tx_valid` held high → two stop-bit periods of 1 between frames. The second start bit begins on the first tick after re-accept. Exactly two `tx_done` pulses.
- Handshake coincident with `baud_tick` → that tick ignored; start bit begins on the next tick (4 clocks later).
- `rst_n`=0 during data bit 3 of 0x3C → next edge gives `tx`=1, `tx_ready`=1, no `tx_done`. A fresh 0x3C then transmits correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and parity mode constants,
// common to the TX serializer and the RX block.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

endpackage

// File: rtl/uart_tx_serializer.sv
// UART transmitter: accepts one word over valid/ready and shifts it out LSB
// first, framed by start, optional parity and 1-2 stop bits, paced by baud_tick.
module uart_tx_serializer #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  import uart_pkg::*;

  localparam int                CNT_W      = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0]  BIT_LAST   = CNT_W'(DATA_BITS - 1);
  localparam logic              STOP_LAST  = (STOP_BITS == 2);
  localparam logic              HAS_PARITY = (PARITY != PAR_NONE);

  uart_state_e          state, state_d;
  logic                 tx_d;
  logic                 done_d;
  logic [CNT_W-1:0]     bit_cnt, bit_cnt_d;
  logic                 stop_cnt, stop_cnt_d;
  logic [DATA_BITS-1:0] shreg, shreg_d;
  logic                 par_q, par_d;
  logic                 parity_calc;

  // The parameter PARITY shadows the imported state of the same name, so that
  // state is always written with its package scope below.
  assign parity_calc = (PARITY == PAR_ODD) ? ~(^tx_data) : ^tx_data;

  assign tx_ready = (state == IDLE);
  assign tx_busy  = ~tx_ready;

  // NOTE: every signal written here gets its hold value first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state;
    tx_d       = tx;
    done_d     = 1'b0;
    bit_cnt_d  = bit_cnt;
    stop_cnt_d = stop_cnt;
    shreg_d    = shreg;
    par_d      = par_q;

    case (state)
      IDLE: begin
        if (tx_valid) begin
          shreg_d = tx_data;
          par_d   = parity_calc;
          state_d = SYNC;
        end
      end

      SYNC: begin
        if (baud_tick) begin
          tx_d    = 1'b0;
          state_d = START;
        end
      end

      START: begin
        if (baud_tick) begin
          tx_d      = shreg[0];
          shreg_d   = shreg >> 1;
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end

      DATA: begin
        if (baud_tick) begin
          if (bit_cnt == BIT_LAST) begin
            if (HAS_PARITY) begin
              tx_d    = par_q;
              state_d = uart_pkg::PARITY;
            end else begin
              tx_d       = 1'b1;
              stop_cnt_d = 1'b0;
              state_d    = STOP;
            end
          end else begin
            tx_d      = shreg[0];
            shreg_d   = shreg >> 1;
            bit_cnt_d = bit_cnt + CNT_W'(1);
          end
        end
      end

      uart_pkg::PARITY: begin
        if (baud_tick) begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = STOP;
        end
      end

      STOP: begin
        if (baud_tick) begin
          if (stop_cnt == STOP_LAST) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            stop_cnt_d = stop_cnt + 1'b1;
          end
        end
      end

      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
    end else begin
      state    <= state_d;
      tx       <= tx_d;
      tx_done  <= done_d;
      bit_cnt  <= bit_cnt_d;
      stop_cnt <= stop_cnt_d;
    end
  end

  // NOTE: the shift register and parity bit are only read after a handshake
  // has loaded them, so they carry no reset.
  always_ff @(posedge clock) begin
    shreg <= shreg_d;
    par_q <= par_d;
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: four instances (8N1, 8E1, 8O1, 8N2)
// share clock, reset and a baud tick every 4 clocks; frames are captured per tick.
module tb_uart_tx_serializer;

  logic       clock = 1'b0;
  logic       rst_n;
  logic       baud_tick;
  logic [3:0] valid_v;
  logic [3:0] tx_w, ready_w, busy_w, done_w;
  logic [7:0] data_v [4];

  int   errors = 0;
  int   checks = 0;
  int   phase = 0;
  bit   tick_on = 1'b0;
  logic last_tick = 1'b0;
  int   busy_bad = 0;
  bit   mon_en = 1'b0;

  typedef struct {
    int          idx;
    logic [7:0]  data;
    logic [0:10] exp;    // line value after each tick, in transmit order, zero padded
    int          nbits;
    string       name;
  } frame_t;

  frame_t frames [5];

  always #5 clock = ~clock;

  uart_tx_serializer #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_8n1 (
    .clock(clock), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(data_v[0]),
    .tx_valid(valid_v[0]), .tx_ready(ready_w[0]), .tx(tx_w[0]),
    .tx_busy(busy_w[0]), .tx_done(done_w[0]));

  uart_tx_serializer #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_8e1 (
    .clock(clock), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(data_v[1]),
    .tx_valid(valid_v[1]), .tx_ready(ready_w[1]), .tx(tx_w[1]),
    .tx_busy(busy_w[1]), .tx_done(done_w[1]));

  uart_tx_serializer #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_8o1 (
    .clock(clock), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(data_v[2]),
    .tx_valid(valid_v[2]), .tx_ready(ready_w[2]), .tx(tx_w[2]),
    .tx_busy(busy_w[2]), .tx_done(done_w[2]));

  uart_tx_serializer #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut_8n2 (
    .clock(clock), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(data_v[3]),
    .tx_valid(valid_v[3]), .tx_ready(ready_w[3]), .tx(tx_w[3]),
    .tx_busy(busy_w[3]), .tx_done(done_w[3]));

  // Pre-edge values are stable here, before the DUT's registers update.
  always @(posedge clock) begin
    if (mon_en && (busy_w !== ~ready_w)) busy_bad++;
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  // Wait for one rising edge, then settle at the falling edge and set up the
  // tick for the next rising edge. last_tick tells whether the edge just
  // passed carried a baud_tick.
  task automatic advance();
    last_tick = baud_tick;
    @(negedge clock);
    if (tick_on) begin
      phase     = (phase + 1) % 4;
      baud_tick = (phase == 3);
    end else begin
      baud_tick = 1'b0;
    end
  endtask

  task automatic run_frame(input int idx, input logic [7:0] data, input logic [0:10] exp,
                           input int nbits, input bit align, input int exp_lat,
                           input string name);
    int          n;
    int          ticks;
    int          lat;
    int          dones;
    bit          done_seen;
    bit          stable_ok;
    logic        prev_tx;
    logic        ready_at_done;
    logic [0:10] got;

    n = 0;
    while (ready_w[idx] !== 1'b1 && n < 200) begin
      advance();
      n++;
    end
    check({name, " ready_before"}, 32'(ready_w[idx]), 32'd1);

    if (align) begin
      n = 0;
      while (baud_tick !== 1'b1 && n < 8) begin
        advance();
        n++;
      end
    end

    data_v[idx]  = data;
    valid_v[idx] = 1'b1;
    advance();
    valid_v[idx] = 1'b0;
    data_v[idx]  = ~data;
    check({name, " ready_fell"}, 32'(ready_w[idx]), 32'd0);
    check({name, " tx_hold_after_accept"}, 32'(tx_w[idx]), 32'd1);

    got           = '0;
    ticks         = 0;
    lat           = -1;
    dones         = 0;
    done_seen     = 1'b0;
    stable_ok     = 1'b1;
    ready_at_done = 1'b0;
    prev_tx       = tx_w[idx];
    n             = 0;
    while (!done_seen && n < 200) begin
      advance();
      n++;
      if (last_tick) begin
        ticks++;
        if (lat < 0) lat = n;
        if (ticks <= nbits) got[ticks-1] = tx_w[idx];
      end else if (tx_w[idx] !== prev_tx) begin
        stable_ok = 1'b0;
      end
      prev_tx = tx_w[idx];
      if (done_w[idx] === 1'b1) begin
        dones++;
        done_seen     = 1'b1;
        ready_at_done = ready_w[idx];
      end
    end

    check({name, " done_seen"}, 32'(done_seen), 32'd1);
    check({name, " bits"}, 32'(got), 32'(exp));
    check({name, " tick_periods"}, 32'(ticks), 32'(nbits + 1));
    check({name, " ready_with_done"}, 32'(ready_at_done), 32'd1);
    check({name, " tx_only_on_tick"}, 32'(stable_ok), 32'd1);
    if (exp_lat >= 0) check({name, " start_latency"}, 32'(lat), 32'(exp_lat));

    for (int i = 0; i < 6; i++) begin
      advance();
      if (done_w[idx] === 1'b1) dones++;
    end
    check({name, " done_pulses"}, 32'(dones), 32'd1);
  endtask

  initial begin
    int          n;
    int          samples;
    int          hs;
    int          dones;
    bit          idle_ok;
    bit          hs_edge;
    logic        prev_ready;
    logic [4:0]  seen0, seen1;
    logic [0:23] stream;
    logic [0:23] stream_exp;

    frames[0] = '{0, 8'h3C, 11'b00011110010, 10, "8n1_3c_fresh"};
    frames[1] = '{0, 8'hA5, 11'b01010010110, 10, "8n1_a5"};
    frames[2] = '{1, 8'h07, 11'b01110000011, 11, "8e1_07"};
    frames[3] = '{2, 8'h07, 11'b01110000001, 11, "8o1_07"};
    frames[4] = '{3, 8'h5A, 11'b00101101011, 11, "8n2_5a"};

    rst_n     = 1'b0;
    baud_tick = 1'b0;
    valid_v   = '0;
    for (int i = 0; i < 4; i++) data_v[i] = 8'h00;

    // Reset, then idle with ticks running and no valid.
    tick_on = 1'b1;
    for (int i = 0; i < 3; i++) advance();
    check("reset tx", 32'(tx_w), 32'hF);
    check("reset ready", 32'(ready_w), 32'hF);
    check("reset busy", 32'(busy_w), 32'h0);
    check("reset done", 32'(done_w), 32'h0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    idle_ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      advance();
      if (tx_w !== 4'hF || ready_w !== 4'hF || done_w !== 4'h0) idle_ok = 1'b0;
    end
    check("idle_100_cycles", 32'(idle_ok), 32'd1);

    // Abort mid-frame: reset during data bit 3 (0x3C has a 1 there, 0x34 a 0).
    data_v[0]  = 8'h3C;
    data_v[1]  = 8'h34;
    valid_v[0] = 1'b1;
    valid_v[1] = 1'b1;
    advance();
    valid_v[0] = 1'b0;
    valid_v[1] = 1'b0;
    samples = 0;
    seen0   = '0;
    seen1   = '0;
    n       = 0;
    while (samples < 5 && n < 100) begin
      advance();
      n++;
      if (last_tick) begin
        seen0[samples] = tx_w[0];
        seen1[samples] = tx_w[1];
        samples++;
      end
    end
    check("abort reached_bit3", 32'(samples), 32'd5);
    check("abort 3c_prefix", 32'(seen0), 32'b11000);
    check("abort 34_prefix", 32'(seen1), 32'b01000);
    rst_n = 1'b0;
    advance();
    check("abort tx_idle", 32'(tx_w[1:0]), 32'b11);
    check("abort ready", 32'(ready_w[1:0]), 32'b11);
    check("abort busy", 32'(busy_w[1:0]), 32'b00);
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      if (done_w[1:0] !== 2'b00) dones++;
      advance();
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (done_w[1:0] !== 2'b00) dones++;
      advance();
    end
    check("abort no_done", 32'(dones), 32'd0);

    // Table of single frames, fresh 0x3C first.
    for (int f = 0; f < 5; f++) begin
      run_frame(frames[f].idx, frames[f].data, frames[f].exp, frames[f].nbits,
                1'b0, -1, frames[f].name);
    end

    // Handshake on the same edge as a tick: start bit comes one tick period later.
    run_frame(0, 8'hA5, 11'b01010010110, 10, 1'b1, 4, "8n1_a5_coincident");

    // Back-to-back on 8N2 with valid held high; data changes while busy.
    stream_exp = 24'b000000000111011111111111;
    stream     = '0;
    samples    = 0;
    hs         = 0;
    dones      = 0;
    n          = 0;
    prev_ready = ready_w[3];
    data_v[3]  = 8'h00;
    valid_v[3] = 1'b1;
    while (dones < 2 && n < 400) begin
      advance();
      n++;
      hs_edge = prev_ready && valid_v[3];
      if (hs_edge) begin
        hs++;
        if (hs == 1) data_v[3] = 8'hFF;
        else valid_v[3] = 1'b0;
      end
      if (last_tick && !hs_edge) begin
        if (samples < 24) stream[samples] = tx_w[3];
        samples++;
      end
      if (done_w[3] === 1'b1) dones++;
      prev_ready = ready_w[3];
    end
    valid_v[3] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      advance();
      if (done_w[3] === 1'b1) dones++;
    end
    check("b2b handshakes", 32'(hs), 32'd2);
    check("b2b tick_samples", 32'(samples), 32'd24);
    check("b2b stream", 32'(stream), 32'(stream_exp));
    check("b2b done_pulses", 32'(dones), 32'd2);
    check("b2b ready_end", 32'(ready_w[3]), 32'd1);

    check("busy_eq_not_ready", 32'(busy_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
